// File: rtl/cgra_pkg.sv
// rtl/cgra_pkg.sv - shared flit layout for the CGRA mesh (NIC, router, PE)
package cgra_pkg;

    localparam int CGRA_COORD_W   = 4;
    localparam int CGRA_PAYLOAD_W = 16;
    localparam int CGRA_FLIT_W    = 4 * CGRA_COORD_W + CGRA_PAYLOAD_W;

    typedef struct packed {
        logic [CGRA_COORD_W-1:0]   dst_x;
        logic [CGRA_COORD_W-1:0]   dst_y;
        logic [CGRA_COORD_W-1:0]   src_x;
        logic [CGRA_COORD_W-1:0]   src_y;
        logic [CGRA_PAYLOAD_W-1:0] payload;
    } flit_t;

    // Field offsets for an arbitrary coordinate/payload width split.
    function automatic int src_y_lsb(input int cw, input int pw);
        return pw + 0 * cw;
    endfunction

    function automatic int src_x_lsb(input int cw, input int pw);
        return pw + cw;
    endfunction

    function automatic int dst_y_lsb(input int cw, input int pw);
        return pw + 2 * cw;
    endfunction

    function automatic int dst_x_lsb(input int cw, input int pw);
        return pw + 3 * cw;
    endfunction

endpackage

// File: rtl/cgra_sync_fifo.sv
// rtl/cgra_sync_fifo.sv - single-clock FIFO with occupancy count and zeroed empty output
module cgra_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Readiness depends on stored occupancy only; a same-cycle pop never frees a full queue.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + CW'(1);
        if (do_pop && !do_push) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    // Masking keeps stale storage invisible after reset or a full drain.
    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/cgra_edge_nic.sv
// rtl/cgra_edge_nic.sv - mesh-edge NIC: host command packetizer and RX ejection queue
module cgra_edge_nic
    import cgra_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int COORD_WIDTH   = 4,
    parameter int PAYLOAD_WIDTH = 16,
    parameter int X_COORD       = 0,
    parameter int Y_COORD       = 0,
    parameter int TX_DEPTH      = 4,
    parameter int RX_DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tx_valid,
    input  logic [COORD_WIDTH-1:0]   tx_dst_x,
    input  logic [COORD_WIDTH-1:0]   tx_dst_y,
    input  logic [PAYLOAD_WIDTH-1:0] tx_payload,
    output logic                     tx_ready,
    output logic [DATA_WIDTH-1:0]    flit_out,
    output logic                     flit_valid_out,
    input  logic                     flit_ready_in,
    input  logic [DATA_WIDTH-1:0]    flit_in,
    input  logic                     flit_valid_in,
    output logic                     flit_ready_out,
    output logic                     rx_valid,
    output logic [COORD_WIDTH-1:0]   rx_src_x,
    output logic [COORD_WIDTH-1:0]   rx_src_y,
    output logic [PAYLOAD_WIDTH-1:0] rx_payload,
    input  logic                     rx_ready,
    output logic [15:0]              tx_count,
    output logic [15:0]              rx_count,
    output logic                     err_misroute
);
    localparam int DX_LSB = dst_x_lsb(COORD_WIDTH, PAYLOAD_WIDTH);
    localparam int DY_LSB = dst_y_lsb(COORD_WIDTH, PAYLOAD_WIDTH);
    localparam int SY_LSB = src_y_lsb(COORD_WIDTH, PAYLOAD_WIDTH);
    localparam int RXW    = DATA_WIDTH - 2 * COORD_WIDTH;
    localparam logic [COORD_WIDTH-1:0] MY_X = COORD_WIDTH'(X_COORD);
    localparam logic [COORD_WIDTH-1:0] MY_Y = COORD_WIDTH'(Y_COORD);

    logic                          tx_full, tx_empty, rx_full, rx_empty;
    logic [$clog2(TX_DEPTH):0]     tx_cnt;
    logic [$clog2(RX_DEPTH):0]     rx_cnt;
    logic [RXW-1:0]                rx_head;
    logic                          rx_accept, dst_match, rx_push, tx_pop;
    logic [15:0]                   tx_count_q, tx_count_d, rx_count_q, rx_count_d;
    logic                          err_q, err_d;
    logic                          unused_cnt;

    assign unused_cnt = ^{tx_cnt, rx_cnt};

    cgra_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (tx_valid),
        .din_i   ({tx_dst_x, tx_dst_y, MY_X, MY_Y, tx_payload}),
        .pop_i   (flit_ready_in),
        .dout_o  (flit_out),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_cnt)
    );

    assign tx_ready       = !tx_full;
    assign flit_valid_out = !tx_empty;
    assign tx_pop         = flit_valid_out && flit_ready_in;

    // Misrouted flits are still accepted so a bad sender cannot wedge the router.
    assign flit_ready_out = !rx_full;
    assign rx_accept      = flit_valid_in && flit_ready_out;
    assign dst_match      = (flit_in[DX_LSB +: COORD_WIDTH] == MY_X) &&
                            (flit_in[DY_LSB +: COORD_WIDTH] == MY_Y);
    assign rx_push        = rx_accept && dst_match;

    cgra_sync_fifo #(.WIDTH(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rx_push),
        .din_i   (flit_in[RXW-1:0]),
        .pop_i   (rx_ready),
        .dout_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_cnt)
    );

    assign rx_valid   = !rx_empty;
    assign rx_payload = rx_head[PAYLOAD_WIDTH-1:0];
    assign rx_src_y   = rx_head[SY_LSB +: COORD_WIDTH];
    assign rx_src_x   = rx_head[SY_LSB + COORD_WIDTH +: COORD_WIDTH];

    always_comb begin
        tx_count_d = tx_count_q;
        rx_count_d = rx_count_q;
        err_d      = err_q;
        if (tx_pop)                 tx_count_d = tx_count_q + 16'd1;
        if (rx_push)                rx_count_d = rx_count_q + 16'd1;
        if (rx_accept && !dst_match) err_d     = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            err_q      <= err_d;
        end
    end

    assign tx_count     = tx_count_q;
    assign rx_count     = rx_count_q;
    assign err_misroute = err_q;

endmodule

// File: doc/cgra_edge_nic.md
# cgra_edge_nic

Host-side network interface that sits on one mesh-edge port of the CGRA array and terminates the NoC flit protocol used by the tiles. It packetizes host commands into 32-bit flits with its own coordinates as source and injects them into the adjacent router. It also ejects flits arriving from the mesh into a receive queue the host drains. Both directions are buffered, use valid/ready flow control and carry traffic counters.

## Interface
- DATA_WIDTH, 32, flit width; must equal 4*COORD_WIDTH + PAYLOAD_WIDTH
- COORD_WIDTH, 4, width of each X/Y coordinate field
- PAYLOAD_WIDTH, 16, payload field width
- X_COORD, 0, this NIC's X coordinate (source field on TX, match on RX)
- Y_COORD, 0, this NIC's Y coordinate
- TX_DEPTH, 4, TX queue entries, power of two ≥2
- RX_DEPTH, 4, RX queue entries, power of two ≥2

- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- tx_valid  in  1  host presents a command
- tx_dst_x  in  COORD_WIDTH  destination X
- tx_dst_y  in  COORD_WIDTH  destination Y
- tx_payload  in  PAYLOAD_WIDTH  payload
- tx_ready  out  1  TX queue can accept (not full)
- flit_out  out  DATA_WIDTH  flit to mesh router
- flit_valid_out  out  1  flit_out valid
- flit_ready_in  in  1  router accepts flit
- flit_in  in  DATA_WIDTH  flit from mesh router
- flit_valid_in  in  1  flit_in valid
- flit_ready_out  out  1  NIC accepts flit (RX queue not full)
- rx_valid  out  1  RX queue head valid
- rx_src_x  out  COORD_WIDTH  head source X
- rx_src_y  out  COORD_WIDTH  head source Y
- rx_payload  out  PAYLOAD_WIDTH  head payload
- rx_ready  in  1  host pops head
- tx_count  out  16  flits injected, wraps at 2^16
- rx_count  out  16  flits enqueued to RX, wraps
- err_misroute  out  1  sticky: flit with wrong destination received

## Operation
- Flit format: [31:28] dst_x, [27:24] dst_y, [23:20] src_x, [19:16] src_y, [15:0] payload (offsets scale with parameters).
- Transfer on any channel occurs iff valid and ready are high in the same cycle.
- TX: accepted command is enqueued as a complete flit with src = {X_COORD, Y_COORD}. Queue head drives flit_out; flit_valid_out = TX non-empty. Head popped on flit_valid_out && flit_ready_in; tx_count increments.
- RX: flit_ready_out = RX not full. Accepted flit with dst == {X_COORD, Y_COORD} is enqueued, rx_count increments. Accepted flit with mismatching dst is consumed and discarded, err_misroute set; rx_count unchanged.
- err_misroute clears only on reset.
- Output holding: flit_out/rx_* stay stable while valid is high and not yet accepted.
- Queues are FIFO order; no reordering, no drops other than misroute discard.

## Timing
- Reset (async assert, sync deassert via rst_n): both queues empty; flit_valid_out=0, rx_valid=0, flit_out=0, rx_* data=0, tx_ready=1, flit_ready_out=1, counters=0, err_misroute=0.
- Latency: command accepted at edge N -> flit_valid_out high after edge N (cycle N+1) if queue was empty. Flit accepted at N -> rx_valid at N+1.
- Full throughput: one push and one pop per queue per cycle sustained.
- tx_ready / flit_ready_out are functions of occupancy only; when full they stay low even if a pop occurs the same cycle (no combinational ready-through).
- Simultaneous push and pop when non-empty and non-full: occupancy unchanged, both complete.
- Pop request on empty queue (rx_ready with rx_valid=0) is ignored.
- Pointers wrap modulo depth; full/empty by count of width clog2(DEPTH)+1.
- Counters wrap 0xFFFF -> 0x0000 silently.
- Reset mid-transfer discards all queued flits; no partial state survives.

## Structure
- cgra_pkg: flit field offset constants and packed flit typedef (dst_x, dst_y, src_x, src_y, payload), shared with the router and PE.
- Sub-module cgra_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), instantiated for TX and RX.
- Top holds packing/unpacking, destination match, counters, sticky flag.

## Test plan
- Reset then one command (dst 2,3, payload 0xBEEF), flit_ready_in=1, X_COORD=Y_COORD=0 -> flit_out=0x2300BEEF at cycle N+1, tx_count=1.
- flit_ready_in=0, push 5 commands -> 4 accepted, tx_ready low after 4th; release ready -> 4 flits exit in order, tx_count=4.
- Inject flit 0x00A1_1234 (dst 0,0, src A,1) -> rx_valid at N+1, rx_src_x=0xA, rx_src_y=1, rx_payload=0x1234, rx_count=1.
- Inject flit with dst 1,0 -> consumed, rx_valid stays 0, err_misroute=1 and persists through further valid traffic.
- rx_ready=0, stream 6 valid flits -> flit_ready_out low after 4; drain -> order preserved; concurrent push/pop at depth 2 keeps occupancy 2.
- Assert rst_n low with both queues holding 3 entries -> all outputs at reset values immediately; no stale flit after release.
